// File: rtl/tx_arb_pkg.sv
// Shared types for the UART-TX frame arbiter and its stall timer.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWait
  } arb_state_e;

  typedef logic       req_idx_t;
  typedef logic [7:0] byte_t;

  localparam int unsigned CntWidth = 8;

endpackage

// File: rtl/tx_stall_timer.sv
// Saturating stall counter; expired stays high while the count sits at the limit.
module tx_stall_timer
  import tx_arb_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                count_en_i,
  input  logic [CntWidth-1:0] limit_i,
  output logic                expired_o
);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_en_i && (cnt_q < limit_i)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q >= limit_i);

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin frame arbiter feeding one byte per two cycles into the TX escape stage.
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int unsigned StallLimit = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tx_ready_i,
  output logic [7:0] data_send_o,
  output logic       write_o,
  output logic       command_o,
  input  logic       req0_valid_i,
  input  logic [7:0] req0_data_i,
  input  logic       req0_last_i,
  output logic       req0_ready_o,
  input  logic       req1_valid_i,
  input  logic [7:0] req1_data_i,
  input  logic       req1_last_i,
  input  logic       req1_cmd_i,
  output logic       req1_ready_o,
  output logic [1:0] grant_o,
  output logic       busy_o,
  output logic       abort_o
);

  localparam byte_t LimitVal = byte_t'(StallLimit);

  arb_state_e state_q, state_d;
  req_idx_t   ptr_q, ptr_d;
  req_idx_t   owner_q, owner_d;
  req_idx_t   win;
  logic [1:0] grant_q, grant_d;
  logic       busy_q, busy_d;
  logic       write_q, write_d;
  logic       abort_q, abort_d;
  logic       command_q, command_d;
  logic       last_q, last_d;
  byte_t      data_q, data_d;

  logic       sel_valid, sel_last, sel_cmd;
  byte_t      sel_data;
  logic       accept, expired;

  // Only the owner's stream is visible; the other requester is ignored entirely.
  assign sel_valid = owner_q ? req1_valid_i : req0_valid_i;
  assign sel_data  = owner_q ? req1_data_i  : req0_data_i;
  assign sel_last  = owner_q ? req1_last_i  : req0_last_i;
  assign sel_cmd   = owner_q ? req1_cmd_i   : 1'b0;

  assign accept = (state_q == StSend) && sel_valid && tx_ready_i && !expired;

  assign req0_ready_o = accept && (owner_q == 1'b0);
  assign req1_ready_o = accept && (owner_q == 1'b1);

  tx_stall_timer u_stall_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (state_q != StSend),
    .count_en_i ((state_q == StSend) && !sel_valid),
    .limit_i    (LimitVal),
    .expired_o  (expired)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    write_d   = 1'b0;
    abort_d   = 1'b0;
    command_d = command_q;
    last_d    = last_q;
    data_d    = data_q;
    win       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req0_valid_i || req1_valid_i) begin
          win     = (req0_valid_i && req1_valid_i) ? ptr_q : req1_valid_i;
          owner_d = win;
          grant_d = win ? 2'b10 : 2'b01;
          busy_d  = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        if (expired) begin
          abort_d = 1'b1;
          grant_d = 2'b00;
          busy_d  = 1'b0;
          ptr_d   = ~owner_q;
          state_d = StIdle;
        end else if (accept) begin
          data_d    = sel_data;
          last_d    = sel_last;
          command_d = sel_cmd;
          write_d   = 1'b1;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (last_q) begin
          grant_d = 2'b00;
          busy_d  = 1'b0;
          ptr_d   = ~owner_q;
          state_d = StIdle;
        end else begin
          state_d = StSend;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      ptr_q     <= 1'b0;
      owner_q   <= 1'b0;
      grant_q   <= 2'b00;
      busy_q    <= 1'b0;
      write_q   <= 1'b0;
      abort_q   <= 1'b0;
      command_q <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      write_q   <= write_d;
      abort_q   <= abort_d;
      command_q <= command_d;
      last_q    <= last_d;
      data_q    <= data_d;
    end
  end

  assign data_send_o = data_q;
  assign write_o     = write_q;
  assign command_o   = command_q;
  assign grant_o     = grant_q;
  assign busy_o      = busy_q;
  assign abort_o     = abort_q;

endmodule
